// File: rtl/fu_div_seq_pkg.sv
// Shared definitions for the sequential divide unit: operation and state
// encodings, default widths and small operation decode helpers.
package fu_div_seq_pkg;

  localparam int DIV_XLEN  = 32;
  localparam int DIV_CNT_W = 6;

  // op[1] selects remainder, op[0] selects unsigned
  typedef enum logic [1:0] {
    DIV_OP_DIV  = 2'b00,
    DIV_OP_DIVU = 2'b01,
    DIV_OP_REM  = 2'b10,
    DIV_OP_REMU = 2'b11
  } div_op_e;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  function automatic logic op_is_signed(input logic [1:0] op);
    return (op == DIV_OP_DIV) || (op == DIV_OP_REM);
  endfunction

  function automatic logic op_is_rem(input logic [1:0] op);
    return (op == DIV_OP_REM) || (op == DIV_OP_REMU);
  endfunction

endpackage

// File: rtl/fu_div_seq_if.sv
// Start/finish handshake and operand/result bus between the control unit
// (master) and the divide unit (slave).
interface fu_div_seq_if #(
  parameter int XLEN = fu_div_seq_pkg::DIV_XLEN
);
  logic            EN;
  logic [1:0]      op;
  logic [XLEN-1:0] A;
  logic [XLEN-1:0] B;
  logic            busy;
  logic            finish;
  logic [XLEN-1:0] res;

  modport master (
    output EN, op, A, B,
    input  busy, finish, res
  );

  modport slave (
    input  EN, op, A, B,
    output busy, finish, res
  );
endinterface

// File: rtl/fu_div_seq_step.sv
// One combinational restoring-division iteration on magnitudes: shift
// {rem, quo} left by one, trial-subtract the divisor, keep the difference
// when it does not borrow and record the quotient bit.
module fu_div_seq_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rem,
  input  logic [XLEN-1:0] quo,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] rem_nxt,
  output logic [XLEN-1:0] quo_nxt
);

  // rem < divisor on entry, so the shifted value fits XLEN+1 bits and the
  // top bit of the difference is exactly the borrow
  logic [XLEN:0] shifted;
  logic [XLEN:0] diff;

  // trial subtract and restore
  always_comb begin
    shifted = {rem, quo[XLEN-1]};
    diff    = shifted - {1'b0, divisor};
    quo_nxt = {quo[XLEN-2:0], ~diff[XLEN]};
    if (diff[XLEN]) begin
      rem_nxt = shifted[XLEN-1:0];
    end else begin
      rem_nxt = diff[XLEN-1:0];
    end
  end

endmodule

// File: rtl/fu_div_seq.sv
// Multi-cycle radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// Divide-by-zero and signed overflow resolve at acceptance in one cycle;
// all other operations iterate XLEN times on operand magnitudes and apply
// the sign fixup as the result is registered.
//
//  state  | meaning
//  -------+-----------------------------------------------------------
//  S_IDLE | waiting for EN
//  S_CALC | iterating, one restoring step per edge (busy = 1)
//  S_DONE | result registered, finish = 1; EN here starts the next op
module fu_div_seq
  import fu_div_seq_pkg::*;
#(
  parameter int XLEN  = DIV_XLEN,
  parameter int CNT_W = DIV_CNT_W
) (
  input  logic         clk,
  input  logic         rst,
  fu_div_seq_if.slave  bus
);

  localparam logic [CNT_W-1:0] LAST     = CNT_W'(XLEN - 1);
  localparam logic [XLEN-1:0]  MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0]  ALL_ONES = '1;

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [XLEN-1:0]  rem_q;
  logic [XLEN-1:0]  quo_q;
  logic [XLEN-1:0]  dvs_q;
  logic [XLEN-1:0]  res_q;
  logic             is_rem_q;
  logic             qneg_q;
  logic             rneg_q;

  logic [XLEN-1:0]  rem_nxt;
  logic [XLEN-1:0]  quo_nxt;

  logic             accept;
  logic             sgn;
  logic             a_neg;
  logic             b_neg;
  logic             b_zero;
  logic             ovf;
  logic [XLEN-1:0]  mag_a;
  logic [XLEN-1:0]  mag_b;
  logic [XLEN-1:0]  special_res;
  logic [XLEN-1:0]  fix_res;

  fu_div_seq_step #(.XLEN(XLEN)) u_step (
    .rem     (rem_q),
    .quo     (quo_q),
    .divisor (dvs_q),
    .rem_nxt (rem_nxt),
    .quo_nxt (quo_nxt)
  );

  // operand decode at the accepting edge: magnitudes, signs, special cases
  always_comb begin
    accept = bus.EN && ((state == S_IDLE) || (state == S_DONE));
    sgn    = op_is_signed(bus.op);
    a_neg  = sgn & bus.A[XLEN-1];
    b_neg  = sgn & bus.B[XLEN-1];
    mag_a  = a_neg ? (~bus.A + 1'b1) : bus.A;
    mag_b  = b_neg ? (~bus.B + 1'b1) : bus.B;
    b_zero = (bus.B == '0);
    ovf    = sgn && (bus.A == MIN_NEG) && (bus.B == ALL_ONES);
    if (b_zero) begin
      special_res = op_is_rem(bus.op) ? bus.A : ALL_ONES;
    end else begin
      special_res = op_is_rem(bus.op) ? '0 : MIN_NEG;
    end
  end

  // sign fixup applied to the final step's outputs as DONE is entered
  always_comb begin
    if (is_rem_q) begin
      fix_res = rneg_q ? (~rem_nxt + 1'b1) : rem_nxt;
    end else begin
      fix_res = qneg_q ? (~quo_nxt + 1'b1) : quo_nxt;
    end
  end

  // control FSM, iteration datapath and result register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      res_q    <= '0;
      is_rem_q <= 1'b0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
    end else if (state == S_CALC) begin
      rem_q <= rem_nxt;
      quo_q <= quo_nxt;
      cnt   <= cnt + 1'b1;
      if (cnt == LAST) begin
        res_q <= fix_res;
        state <= S_DONE;
      end
    end else if (accept) begin
      if (b_zero || ovf) begin
        res_q <= special_res;
        state <= S_DONE;
      end else begin
        rem_q    <= '0;
        quo_q    <= mag_a;
        dvs_q    <= mag_b;
        cnt      <= '0;
        is_rem_q <= op_is_rem(bus.op);
        qneg_q   <= a_neg ^ b_neg;
        rneg_q   <= a_neg;
        state    <= S_CALC;
      end
    end else begin
      state <= S_IDLE;
    end
  end

  assign bus.busy   = (state == S_CALC);
  assign bus.finish = (state == S_DONE);
  assign bus.res    = res_q;

endmodule
